// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one byte-level SPI master between NUM_REQ clients.
// Round-robin arbitration, multi-byte transactions, per-byte timeout and inter-byte gap.
module spi_xfer_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int GAP_CYCLES = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_len,
   input  logic [8*NUM_REQ-1:0]   tx_data,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     tx_ack,
   output logic [7:0]             rx_data,
   output logic [NUM_REQ-1:0]     rx_valid,
   output logic [NUM_REQ-1:0]     done,
   output logic [NUM_REQ-1:0]     err,
   output logic [7:0]             spi_data_send,
   output logic                   spi_data_valid,
   input  logic [7:0]             spi_data_recv,
   input  logic                   spi_recv_completed,
   output logic                   busy
);

   localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_LOAD,
      S_STROBE,
      S_WAIT,
      S_GAP,
      S_FINISH
   } state_e;

   state_e             state_q, state_d;
   logic [IW-1:0]      g_q, g_d;
   logic [IW-1:0]      last_q, last_d;
   logic [IW-1:0]      pick_idx, cand_idx;
   logic [7:0]         rem_q, rem_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               abort_q, abort_d;
   logic               rx_fire;
   logic [NUM_REQ-1:0] g_oh;

   logic [NUM_REQ-1:0] grant_q, tx_ack_q, rx_valid_q, done_q, err_q;
   logic [7:0]         rx_data_q, spi_send_q;
   logic               spi_valid_q, busy_q;

   assign grant          = grant_q;
   assign tx_ack         = tx_ack_q;
   assign rx_data        = rx_data_q;
   assign rx_valid       = rx_valid_q;
   assign done           = done_q;
   assign err            = err_q;
   assign spi_data_send  = spi_send_q;
   assign spi_data_valid = spi_valid_q;
   assign busy           = busy_q;

   // Round-robin pick: scan offsets high to low so the nearest requester after last_q wins.
   always_comb begin
      pick_idx = last_q;
      cand_idx = '0;
      for (int unsigned off = NUM_REQ; off > 0; off--) begin
         cand_idx = IW'((32'(last_q) + off) % NUM_REQ);
         if (req[cand_idx]) begin
            pick_idx = cand_idx;
         end
      end
   end

   // One-hot of the index owning the bus in the next state.
   always_comb begin
      g_oh      = '0;
      g_oh[g_d] = 1'b1;
   end

   // Next-state logic for the transaction sequencer.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      last_d  = last_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      rx_fire = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               g_d     = pick_idx;
               rem_d   = req_len[{pick_idx, 3'b000} +: 8];
               abort_d = 1'b0;
               state_d = S_ARB;
            end
         end
         S_ARB: begin
            state_d = (rem_q == 8'd0) ? S_FINISH : S_LOAD;
         end
         S_LOAD: begin
            state_d = S_STROBE;
         end
         S_STROBE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Completion takes priority over a timeout landing in the same cycle.
            if (spi_recv_completed) begin
               rx_fire = 1'b1;
               rem_d   = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = S_FINISH;
               end else begin
                  cnt_d   = '0;
                  state_d = S_GAP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(TIMEOUT - 1)) begin
                  abort_d = 1'b1;
                  state_d = S_FINISH;
               end
            end
         end
         S_GAP: begin
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FINISH: begin
            last_d  = g_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         g_q         <= '0;
         last_q      <= IW'(NUM_REQ - 1);
         rem_q       <= '0;
         cnt_q       <= '0;
         abort_q     <= 1'b0;
         grant_q     <= '0;
         tx_ack_q    <= '0;
         rx_valid_q  <= '0;
         done_q      <= '0;
         err_q       <= '0;
         rx_data_q   <= '0;
         spi_send_q  <= '0;
         spi_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         last_q      <= last_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         abort_q     <= abort_d;
         grant_q     <= (state_d != S_IDLE) ? g_oh : '0;
         tx_ack_q    <= (state_d == S_LOAD) ? g_oh : '0;
         rx_valid_q  <= rx_fire ? g_oh : '0;
         done_q      <= (state_d == S_FINISH) ? g_oh : '0;
         err_q       <= (state_d == S_FINISH && abort_d) ? g_oh : '0;
         spi_valid_q <= (state_d == S_STROBE);
         busy_q      <= (state_d != S_IDLE);
         if (state_q == S_LOAD) begin
            spi_send_q <= tx_data[{g_q, 3'b000} +: 8];
         end
         if (rx_fire) begin
            rx_data_q <= spi_data_recv;
         end
      end
   end

endmodule
